// File: rtl/cache_pkg.sv
// Shared definitions for the cache request path.
//   - Default address/data widths used by the handler.
//   - Handler state encoding.
package cache_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    CHECK    = 3'd2,
    MEM_RD   = 3'd3,
    FILL     = 3'd4,
    WR_CACHE = 3'd5,
    MEM_WR   = 3'd6,
    RESP     = 3'd7
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer: a clear/enable counter whose terminal flag marks the last
// permitted wait cycle (MEM_TIMEOUT-1). The count holds at the terminal value.
//   clk, reset (sync, active-low)
//   clr  : forces the count to zero
//   en   : advances the count by one
//   done : count has reached MEM_TIMEOUT-1
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int            TW   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/cache_miss_handler.sv
// Cache miss handler: sequences processor requests into cache lookups, memory
// fetches with cache fill on a read miss, and write-through with allocate.
// Memory waits are bounded; an expired wait returns an error response.
//   req_*   : processor request (valid/ready handshake, accepted only in IDLE)
//   resp_*  : one-cycle response strobe with data and error flag
//   cache_* : lookup / write strobes toward the cache, hit and data back
//   mem_*   : held request toward main memory, completed by mem_ack
//   hit_cnt, miss_cnt : saturating read statistics
// Every output is a register; nothing combinational reaches an output port.
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  cache_rd_en,
  output logic                  cache_wr_en,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_w_data,
  input  logic [DATA_WIDTH-1:0] cache_r_data,
  input  logic                  cache_hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t                state;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;  // write data, or read data once known
  logic                  in_wait;
  logic                  timer_done;

  // The timer is held clear outside the memory wait states, so it reads zero
  // in the first wait cycle and counts cycles that pass without an ack.
  assign in_wait = (state == MEM_RD) || (state == MEM_WR);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (!in_wait),
    .en    (!mem_ack),
    .done  (timer_done)
  );

  // Outputs are set on the transition into the state that owns them, so each
  // state's strobes appear exactly while the state register holds that state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      cache_rd_en  <= 1'b0;
      cache_wr_en  <= 1'b0;
      cache_addr   <= '0;
      cache_w_data <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      lat_addr     <= '0;
      lat_data     <= '0;
    end else begin
      cache_rd_en <= 1'b0;
      cache_wr_en <= 1'b0;
      resp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            lat_addr   <= req_addr;
            lat_data   <= req_wdata;
            cache_addr <= req_addr;
            if (req_we) begin
              state        <= WR_CACHE;
              cache_wr_en  <= 1'b1;
              cache_w_data <= req_wdata;
            end else begin
              state       <= LOOKUP;
              cache_rd_en <= 1'b1;
            end
          end else begin
            // Ready rises one cycle after reset release, never during reset.
            req_ready <= 1'b1;
          end
        end
        LOOKUP: state <= CHECK;
        CHECK: begin
          if (cache_hit) begin
            lat_data   <= cache_r_data;
            hit_cnt    <= sat_inc(hit_cnt);
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= cache_r_data;
            resp_err   <= 1'b0;
          end else begin
            miss_cnt <= sat_inc(miss_cnt);
            state    <= MEM_RD;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= lat_addr;
          end
        end
        MEM_RD: begin
          // A same-cycle ack beats the timeout.
          if (mem_ack) begin
            mem_req      <= 1'b0;
            lat_data     <= mem_rdata;
            state        <= FILL;
            cache_wr_en  <= 1'b1;
            cache_addr   <= lat_addr;
            cache_w_data <= mem_rdata;
          end else if (timer_done) begin
            mem_req    <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_err   <= 1'b1;
          end
        end
        FILL: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= lat_data;
          resp_err   <= 1'b0;
        end
        WR_CACHE: begin
          state     <= MEM_WR;
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= lat_addr;
          mem_wdata <= lat_data;
        end
        MEM_WR: begin
          if (mem_ack || timer_done) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= lat_data;
            resp_err   <= !mem_ack;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_handler.sv
// Bench for cache_miss_handler: emulated cache and memory around the DUT, a
// transaction-level reference model, directed cases then randomized traffic.
module tb_cache_miss_handler;

  localparam int AW   = 32;
  localparam int DW   = 8;
  localparam int TO   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          cache_rd_en;
  logic          cache_wr_en;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_w_data;
  logic [DW-1:0] cache_r_data = '0;
  logic          cache_hit    = 1'b0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack   = 1'b0;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  cache_miss_handler #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_TIMEOUT(TO),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .cache_rd_en (cache_rd_en),
    .cache_wr_en (cache_wr_en),
    .cache_addr  (cache_addr),
    .cache_w_data(cache_w_data),
    .cache_r_data(cache_r_data),
    .cache_hit   (cache_hit),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hC3;
  endfunction

  // Emulated cache: answers a lookup with hit/data held until the next lookup.
  logic [DW-1:0] emu_cache [logic [AW-1:0]];
  logic          pre_c      = 1'b0;
  logic [AW-1:0] pre_c_addr = '0;
  logic [DW-1:0] pre_c_data = '0;
  int            mon_rd = 0, mon_wr = 0, mon_resp = 0, mon_resp_cyc = 0;
  logic [AW-1:0] mon_wr_addr = '0;
  logic [DW-1:0] mon_wr_data = '0;
  logic [DW-1:0] mon_rdata   = '0;
  logic          mon_err     = 1'b0;

  always @(negedge clk) begin
    if (pre_c) emu_cache[pre_c_addr] = pre_c_data;
    if (cache_rd_en) begin
      mon_rd++;
      if (emu_cache.exists(cache_addr)) begin
        cache_hit    = 1'b1;
        cache_r_data = emu_cache[cache_addr];
      end else begin
        cache_hit    = 1'b0;
        cache_r_data = DW'($urandom);
      end
    end
    if (cache_wr_en) begin
      mon_wr++;
      mon_wr_addr = cache_addr;
      mon_wr_data = cache_w_data;
      emu_cache[cache_addr] = cache_w_data;
    end
    if (resp_valid) begin
      mon_resp++;
      mon_resp_cyc = cyc;
      mon_rdata    = resp_rdata;
      mon_err      = resp_err;
    end
  end

  // Emulated memory: acks in the ack_k-th cycle of a held request (0 = never).
  logic [DW-1:0] emu_mem [logic [AW-1:0]];
  logic          pre_m      = 1'b0;
  logic [AW-1:0] pre_m_addr = '0;
  logic [DW-1:0] pre_m_data = '0;
  int            wait_j = 0, mon_req_cyc = 0, mon_bad = 0;
  int            ack_k = 0;
  logic          force_ack = 1'b0;
  logic [AW-1:0] cur_addr  = '0;
  logic          cur_we    = 1'b0;
  logic [DW-1:0] cur_wdata = '0;

  always @(negedge clk) begin
    if (pre_m) emu_mem[pre_m_addr] = pre_m_data;
    mem_ack   = force_ack;
    mem_rdata = DW'($urandom);
    if (mem_req) begin
      wait_j++;
      mon_req_cyc++;
      if (mem_addr !== cur_addr || mem_we !== cur_we || (cur_we && mem_wdata !== cur_wdata))
        mon_bad++;
      if (ack_k != 0 && wait_j == ack_k) begin
        mem_ack = 1'b1;
        if (mem_we) emu_mem[mem_addr] = mem_wdata;
        else mem_rdata = emu_mem.exists(mem_addr) ? emu_mem[mem_addr] : mem_init(mem_addr);
      end
    end else begin
      wait_j = 0;
    end
  end

  // Reference model state.
  logic [DW-1:0] m_cache [logic [AW-1:0]];
  logic [DW-1:0] m_mem   [logic [AW-1:0]];
  int            m_hit = 0, m_miss = 0;

  int n_assert = 0, n_fail = 0;
  int b_rd, b_wr, b_resp, b_req, b_bad, acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic preload_cache(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_c_addr = a; pre_c_data = d; pre_c = 1'b1;
    step();
    pre_c = 1'b0;
    m_cache[a] = d;
  endtask

  task automatic set_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_m_addr = a; pre_m_data = d; pre_m = 1'b1;
    step();
    pre_m = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("ready_before_req", req_ready, 1);
    b_rd = mon_rd; b_wr = mon_wr; b_resp = mon_resp; b_req = mon_req_cyc; b_bad = mon_bad;
    cur_addr = a; cur_we = we; cur_wdata = d;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    step();
    acc = cyc;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = DW'($urandom);
  endtask

  task automatic run_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int k);
    logic [DW-1:0] e_data;
    logic          e_err;
    logic          acked;
    int            e_lat, e_req, e_wr, e_rd, n;
    acked = (k >= 1 && k <= TO);
    e_err = 1'b0;
    e_wr  = 0;
    e_req = 0;
    e_rd  = we ? 0 : 1;
    if (!we) begin
      if (m_cache.exists(a)) begin
        e_data = m_cache[a];
        e_lat  = 3;
        m_hit  = (m_hit == CMAX) ? CMAX : m_hit + 1;
      end else begin
        m_miss = (m_miss == CMAX) ? CMAX : m_miss + 1;
        if (acked) begin
          e_data     = m_mem.exists(a) ? m_mem[a] : mem_init(a);
          e_wr       = 1;
          e_lat      = k + 4;
          e_req      = k;
          m_cache[a] = e_data;
        end else begin
          e_err  = 1'b1;
          e_data = '0;
          e_lat  = TO + 3;
          e_req  = TO;
        end
      end
    end else begin
      e_data     = d;
      e_wr       = 1;
      m_cache[a] = d;
      if (acked) begin
        e_lat    = 2 + k;
        e_req    = k;
        m_mem[a] = d;
      end else begin
        e_err = 1'b1;
        e_lat = TO + 2;
        e_req = TO;
      end
    end

    ack_k = k;
    issue(we, a, d);
    n = 0;
    while (mon_resp == b_resp && n < 40) begin
      step();
      n++;
    end
    chk("resp_seen", mon_resp - b_resp, 1);
    chk("resp_rdata", mon_rdata, e_data);
    chk("resp_err", mon_err, e_err);
    chk("resp_latency", mon_resp_cyc - acc + 1, e_lat);
    chk("cache_rd_pulses", mon_rd - b_rd, e_rd);
    chk("cache_wr_pulses", mon_wr - b_wr, e_wr);
    if (e_wr != 0) begin
      chk("cache_wr_addr", mon_wr_addr, a);
      chk("cache_wr_data", mon_wr_data, e_data);
    end
    chk("mem_req_cycles", mon_req_cyc - b_req, e_req);
    chk("mem_stable", mon_bad - b_bad, 0);
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
    step();
    chk("resp_single", mon_resp - b_resp, 1);
    chk("ready_after_resp", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    int            r_k;

    // Reset state
    repeat (3) step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_cache_rd", cache_rd_en, 0);
    chk("rst_cache_wr", cache_wr_en, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    reset = 1'b1;
    step();
    chk("ready_after_release", req_ready, 1);

    // Read hit on a preloaded line
    preload_cache(32'h10, 8'hA5);
    run_txn(1'b0, 32'h10, 8'h00, 0);

    // Cold miss then re-read hit
    set_mem(32'h24, 8'h3C);
    run_txn(1'b0, 32'h24, 8'h00, 4);
    run_txn(1'b0, 32'h24, 8'h00, 0);

    // Write-through then read back
    run_txn(1'b1, 32'h08, 8'h55, 2);
    run_txn(1'b0, 32'h08, 8'h00, 0);

    // Timeouts, and an ack on the last permitted cycle
    run_txn(1'b0, 32'h30, 8'h00, 0);
    run_txn(1'b0, 32'h31, 8'h00, TO);
    run_txn(1'b1, 32'h32, 8'h77, 0);
    run_txn(1'b1, 32'h33, 8'h19, TO);

    // Stray mem_ack while idle
    b_resp = mon_resp; b_wr = mon_wr;
    force_ack = 1'b1;
    repeat (3) step();
    chk("stray_mem_req", mem_req, 0);
    chk("stray_resp", mon_resp - b_resp, 0);
    chk("stray_cache_wr", mon_wr - b_wr, 0);
    chk("stray_ready", req_ready, 1);
    force_ack = 1'b0;
    step();

    // Hit counter saturation
    repeat (5) run_txn(1'b0, 32'h10, 8'h00, 0);
    chk("hit_saturated", hit_cnt, CMAX);

    // Reset while waiting on memory
    issue(1'b0, 32'h40, 8'h00);
    ack_k = 0;
    repeat (4) step();
    chk("midrst_mem_req_before", mem_req, 1);
    reset = 1'b0;
    step();
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_cache_rd", cache_rd_en, 0);
    chk("midrst_cache_wr", cache_wr_en, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_hit_cnt", hit_cnt, 0);
    chk("midrst_miss_cnt", miss_cnt, 0);
    chk("midrst_ready", req_ready, 0);
    reset = 1'b1;
    m_hit = 0;
    m_miss = 0;
    repeat (4) step();
    chk("midrst_no_resp", mon_resp - b_resp, 0);
    chk("midrst_ready_after", req_ready, 1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      r_we   = 1'($urandom);
      r_addr = 32'h100 + AW'($urandom_range(0, 7));
      r_data = DW'($urandom);
      r_k    = int'($urandom_range(0, 6));
      repeat ($urandom_range(0, 2)) step();
      run_txn(r_we, r_addr, r_data, r_k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
